// File: rtl/signed_mult_ctrl.sv
// Sequential signed shift-add multiplier: done pulses N+3 cycles after the accepting edge, one multiply per N+4 cycles.
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module signed_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           shift_en,
    output logic           add_en
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        SIGN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic           sign_flag;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mult;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum;
    logic [2*N-1:0] signed_res;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        shift_en   = 1'b0;
        add_en     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: next_state = CALC;
            CALC: begin
                shift_en = 1'b1;
                add_en   = mult[0];
                if (cnt == LAST_CNT) begin
                    next_state = SIGN;
                end
            end
            SIGN: next_state = DONE;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Carry lands in bit N of sum, so the shifted-in top bit is never lost.
    always_comb begin
        sum        = {1'b0, acc[2*N-1:N]} + (mult[0] ? {1'b0, mag_a} : '0);
        signed_res = sign_flag ? ('0 - acc) : acc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sign_flag <= 1'b0;
            mag_a     <= '0;
            mult      <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        sign_flag <= a_in[N-1] ^ b_in[N-1];
                    end
                end
                LOAD: begin
                    // -2^(N-1) negates to itself, which reads correctly as an unsigned magnitude.
                    mag_a <= a_reg[N-1] ? ('0 - a_reg) : a_reg;
                    mult  <= b_reg[N-1] ? ('0 - b_reg) : b_reg;
                    acc   <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    acc  <= {sum, acc[N-1:1]};
                    mult <= mult >> 1;
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SIGN: product <= signed_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// Directed bench for signed_mult_ctrl (N=8): operation-level reference model checked every cycle plus literal result checks.
module tb_signed_mult_ctrl;

    localparam int NN = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NN-1:0] a_in;
    logic [NN-1:0] b_in;
    logic          busy;
    logic          done;
    logic [2*NN-1:0] product;
    logic          shift_en;
    logic          add_en;

    int total = 0;
    int bad   = 0;

    signed_mult_ctrl #(.N(NN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .shift_en (shift_en),
        .add_en   (add_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since the accepting edge, and the arithmetic result.
    bit              model_ok = 0;
    int              phase    = 0;
    logic [2*NN-1:0] exp_prod = '0;
    logic [2*NN-1:0] exp_res  = '0;
    logic [NN-1:0]   exp_mb   = '0;

    always @(posedge clk) begin
        if (!reset) begin
            model_ok = 1;
            phase    = 0;
            exp_prod = '0;
        end else if (model_ok) begin
            if (phase == 0) begin
                if (start) begin
                    int ia;
                    int ib;
                    ia      = $signed(a_in);
                    ib      = $signed(b_in);
                    exp_res = 16'(ia * ib);
                    exp_mb  = 8'((ib < 0) ? -ib : ib);
                    phase   = 1;
                end
            end else if (phase == NN + 3) begin
                phase = 0;
            end else begin
                phase++;
                if (phase == NN + 3) exp_prod = exp_res;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic e_shift;
            logic e_add;
            e_shift = (phase >= 2) && (phase <= NN + 1);
            e_add   = e_shift && exp_mb[phase - 2];
            chk("cyc_busy", 64'(busy), 64'(phase != 0));
            chk("cyc_done", 64'(done), 64'(phase == NN + 3));
            chk("cyc_shift_en", 64'(shift_en), 64'(e_shift));
            chk("cyc_add_en", 64'(add_en), 64'(e_add));
            chk("cyc_product", 64'(product), 64'(exp_prod));
        end
    end

    // Watches negedges until done; lat is the cycle index of done (0 on timeout).
    task automatic wait_done(input bit scramble, output int lat, output int busy_cnt,
                             output int sh, output logic [7:0] mask);
        bit seen;
        seen     = 0;
        lat      = 0;
        busy_cnt = 0;
        sh       = 0;
        mask     = '0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (shift_en) begin
                if (add_en && sh < 8) mask[sh] = 1'b1;
                sh++;
            end
            if (done) begin
                seen = 1;
                lat  = i;
            end
            if (scramble) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                         input string nm, output logic [7:0] mask);
        int lat;
        int bc;
        int sh;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b1, lat, bc, sh, mask);
        chk({nm, "_latency"}, 64'(lat), 64'(11));
        chk({nm, "_product"}, 64'(product), 64'(exp_p));
        chk({nm, "_shifts"}, 64'(sh), 64'(8));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(11));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mask;
        int lat;
        int bc;
        int sh;

        reset = 1'b0;
        start = 1'b1;
        a_in  = 8'h33;
        b_in  = 8'h44;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_product", 64'(product), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_shift_en", 64'(shift_en), 64'(0));
        chk("rst_add_en", 64'(add_en), 64'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_op(8'd3,   8'd5,   16'h000F, "p3x5",      mask);
        do_op(8'hF9,  8'd6,   16'hFFD6, "pm7x6",     mask);
        do_op(8'hF9,  8'hFA,  16'h002A, "pm7xm6",    mask);
        do_op(8'h80,  8'h80,  16'h4000, "pmin_sq",   mask);
        do_op(8'h7F,  8'h80,  16'hC080, "pmax_min",  mask);
        do_op(8'h00,  8'hFF,  16'h0000, "pzero_neg", mask);
        do_op(8'd5,   8'h0B,  16'h0037, "p5x11",     mask);
        chk("strobe_add_mask", 64'(mask), 64'(8'b0000_1011));

        // start pulse during CALC is ignored
        a_in  = 8'd9;
        b_in  = 8'hFD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'd1;
        b_in  = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b1, lat, bc, sh, mask);
        chk("ignore_latency", 64'(lat), 64'(7));
        chk("ignore_product", 64'(product), 64'(16'hFFE5));
        @(posedge clk);
        #1;

        // start held: back-to-back operations
        a_in  = 8'd3;
        b_in  = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1'b0, lat, bc, sh, mask);
        chk("held_first_latency", 64'(lat), 64'(11));
        wait_done(1'b0, lat, bc, sh, mask);
        start = 1'b0;
        chk("held_done_spacing", 64'(lat), 64'(12));
        chk("held_product", 64'(product), 64'(16'h000F));
        @(posedge clk);
        #1;

        // reset at CALC count 4 aborts the operation
        a_in  = 8'd100;
        b_in  = 8'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_product", 64'(product), 64'(0));
        wait_done(1'b0, lat, bc, sh, mask);
        chk("abort_no_done", 64'(lat), 64'(0));
        @(posedge clk);
        #1;
        do_op(8'd2, 8'd2, 16'h0004, "p2x2_after_reset", mask);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
